// File: rtl/bit_deframer.sv
`default_nettype none
// ============================================================================
// Module      : bit_deframer
// Description : Serial sync-word deframer; hunts for SYNC, locks, assembles
//               WIDTH-bit data words and flywheels over isolated bad syncs.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_deframer #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] SYNC       = 8'hA5,
    parameter int               FRAME_LEN  = 4,
    parameter int               MISS_LIMIT = 2
) (
    input  logic             c,
    input  logic             rst,
    input  logic             d,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             locked,
    output logic             overflow
);

    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int WCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int MCW = $clog2(MISS_LIMIT + 1);
    localparam int FCW = $clog2(WIDTH + 1);

    localparam logic [BCW-1:0] c_bit_last  = BCW'(WIDTH - 1);
    localparam logic [WCW-1:0] c_word_last = WCW'(FRAME_LEN - 1);
    localparam logic [MCW-1:0] c_miss_last = MCW'(MISS_LIMIT - 1);
    localparam logic [FCW-1:0] c_fill_min  = FCW'(WIDTH - 1);
    localparam logic [FCW-1:0] c_fill_max  = FCW'(WIDTH);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [BCW-1:0]   bit_q, bit_d;
    logic [WCW-1:0]   word_q, word_d;
    logic [MCW-1:0]   miss_q, miss_d;
    logic [FCW-1:0]   fill_q, fill_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] w_nxt;
    logic             w_word_done;

    always_ff @(posedge c) begin
        if (rst) begin
            state_q <= ST_HUNT;
            sr_q    <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            miss_q  <= '0;
            fill_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            miss_q  <= miss_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        w_nxt       = {sr_q[WIDTH-2:0], d};
        w_word_done = 1'b0;
        state_d     = state_q;
        sr_d        = w_nxt;
        bit_d       = bit_q;
        word_d      = word_q;
        miss_d      = miss_q;
        fill_d      = (fill_q == c_fill_max) ? fill_q : fill_q + 1'b1;

        case (state_q)
            ST_HUNT: begin
                // Fill gate stops stale pre-reset / pre-unlock bits from forming a match
                if (w_nxt == SYNC && fill_q >= c_fill_min) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    word_d  = '0;
                    miss_d  = '0;
                end
            end
            ST_DATA: begin
                bit_d = (bit_q == c_bit_last) ? '0 : bit_q + 1'b1;
                if (bit_q == c_bit_last) begin
                    w_word_done = 1'b1;
                    if (word_q == c_word_last) begin
                        word_d  = '0;
                        state_d = ST_CHECK;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                bit_d = (bit_q == c_bit_last) ? '0 : bit_q + 1'b1;
                if (bit_q == c_bit_last) begin
                    if (w_nxt == SYNC) begin
                        miss_d  = '0;
                        state_d = ST_DATA;
                    end else if (miss_q == c_miss_last) begin
                        miss_d  = '0;
                        fill_d  = '0;
                        state_d = ST_HUNT;
                    end else begin
                        miss_d  = miss_q + 1'b1;
                        state_d = ST_DATA;
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    // One-entry output register: a word arriving while the slot is stalled is lost
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (w_word_done) begin
            if (!valid_q || ready) begin
                data_d  = w_nxt;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    assign data     = data_q;
    assign valid    = valid_q;
    assign overflow = ovf_q;
    assign locked   = (state_q != ST_HUNT);

endmodule
`default_nettype wire
